// File: rtl/baud_tick_gen_frac.sv
// Fractional baud tick generator: a phase accumulator produces oversample
// ticks at f_clk * inc / 2^ACC_WIDTH, with bit-boundary and mid-bit strobes.
// Increment changes are held pending and only take effect at a bit boundary
// (or while stopped / resyncing) so a bit in flight never changes rate.
module baud_tick_gen_frac #(
  parameter int ACC_WIDTH    = 24,
  parameter int OVERSAMPLING = 16,
  parameter int DEFAULT_INC  = 2576980,
  localparam int PW          = $clog2(OVERSAMPLING)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 resync,
  input  logic [ACC_WIDTH-1:0] inc_i,
  input  logic                 inc_we,
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic                 mid_tick,
  output logic [PW-1:0]        os_phase,
  output logic                 inc_busy
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc_active;
  logic [ACC_WIDTH-1:0] inc_pending;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 run;
  logic                 bit_set;
  logic                 mid_set;
  logic                 xfer;

  // Next accumulator value and the strobes it implies this edge
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc_active};
    carry   = sum[ACC_WIDTH];
    run     = enable && !resync;
    bit_set = run && carry && (os_phase == PW'(OVERSAMPLING - 1));
    mid_set = run && carry && (os_phase == PW'(OVERSAMPLING / 2 - 1));
    // Safe points to swap the increment: bit boundary, stopped, or realigning
    xfer    = !enable || resync || bit_set;
  end

  // Phase accumulator, oversample phase counter and registered tick outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (!run) begin
      acc      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      acc      <= sum[ACC_WIDTH-1:0];
      os_tick  <= carry;
      bit_tick <= bit_set;
      mid_tick <= mid_set;
      // OVERSAMPLING is a power of two, so the natural wrap is the modulo
      if (carry) os_phase <= os_phase + 1'b1;
    end
  end

  // Increment double-buffer: writes land in pending, move to active at xfer
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_active  <= ACC_WIDTH'(DEFAULT_INC);
      inc_pending <= ACC_WIDTH'(DEFAULT_INC);
      inc_busy    <= 1'b0;
    end else if (xfer) begin
      if (inc_we) begin
        inc_active  <= inc_i;
        inc_pending <= inc_i;
      end else if (inc_busy) begin
        inc_active  <= inc_pending;
      end
      inc_busy <= 1'b0;
    end else if (inc_we) begin
      inc_pending <= inc_i;
      inc_busy    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Bench for baud_tick_gen_frac (ACC_WIDTH=8, OVERSAMPLING=4, DEFAULT_INC=64):
// directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_baud_tick_gen_frac;
  localparam int AW  = 8;
  localparam int OS  = 4;
  localparam int DEF = 64;
  localparam int MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          resync = 1'b0;
  logic [AW-1:0] inc_i = '0;
  logic          inc_we = 1'b0;
  logic          os_tick, bit_tick, mid_tick, inc_busy;
  logic [1:0]    os_phase;

  int total = 0;
  int bad   = 0;

  baud_tick_gen_frac #(.ACC_WIDTH(AW), .OVERSAMPLING(OS), .DEFAULT_INC(DEF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .resync(resync), .inc_i(inc_i),
    .inc_we(inc_we), .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .os_phase(os_phase), .inc_busy(inc_busy)
  );

  always #5 clk = ~clk;

  // Reference model: accumulator as a plain integer, phase derived from the
  // number of overflows since the last restart.
  int m_acc = 0, m_inc = DEF, m_pend = DEF, m_ticks = 0;
  bit m_busy = 0, e_os = 0, e_bit = 0, e_mid = 0;
  int e_phase = 0;

  always @(posedge clk) begin
    bit at_xfer;
    int s;
    at_xfer = 0;
    if (rst) begin
      m_acc = 0; m_inc = DEF; m_pend = DEF; m_busy = 0; m_ticks = 0;
      e_os = 0; e_bit = 0; e_mid = 0; e_phase = 0;
    end else begin
      if (!enable || resync) begin
        m_acc = 0; m_ticks = 0; e_os = 0; e_bit = 0; e_mid = 0; e_phase = 0;
        at_xfer = 1;
      end else begin
        s = m_acc + m_inc;
        e_os = (s >= MOD);
        m_acc = s % MOD;
        if (e_os) m_ticks++;
        e_phase = m_ticks % OS;
        e_bit = e_os && (m_ticks % OS == 0);
        e_mid = e_os && (m_ticks % OS == OS / 2);
        at_xfer = e_bit;
      end
      if (at_xfer) begin
        if (inc_we) begin m_inc = int'(inc_i); m_pend = int'(inc_i); end
        else if (m_busy) m_inc = m_pend;
        m_busy = 0;
      end else if (inc_we) begin
        m_pend = int'(inc_i); m_busy = 1;
      end
    end
    #1;
    total++;
    if ({os_tick, bit_tick, mid_tick, inc_busy, os_phase} !==
        {e_os, e_bit, e_mid, m_busy, 2'(e_phase)}) begin
      bad++;
      $display("FAIL model t=%0t: got os/bit/mid/busy/phase=%b%b%b%b/%0d want %b%b%b%b/%0d",
               $time, os_tick, bit_tick, mid_tick, inc_busy, os_phase,
               e_os, e_bit, e_mid, m_busy, e_phase);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reset for one edge, then release with enable held high; next edge is cycle 1
  task automatic start();
    rst = 1; enable = 0; resync = 0; inc_we = 0; inc_i = '0;
    step(1);
    rst = 0; enable = 1;
  endtask

  initial begin
    step(2);

    // Basic cadence at the default increment
    start();
    chk("reset_busy", int'(inc_busy), 0);
    step(3);  chk("c3_os", int'(os_tick), 0);
    step(1);  chk("c4_os", int'(os_tick), 1); chk("c4_phase", int'(os_phase), 1);
    step(4);  chk("c8_mid", int'(mid_tick), 1); chk("c8_phase", int'(os_phase), 2);
    step(4);  chk("c12_phase", int'(os_phase), 3); chk("c12_bit", int'(bit_tick), 0);
    step(4);  chk("c16_bit", int'(bit_tick), 1); chk("c16_os", int'(os_tick), 1);
    chk("c16_phase", int'(os_phase), 0);

    // Pending increment waits for the bit boundary, then 3,3,2 spacing
    start();
    step(4); inc_we = 1; inc_i = 8'd96; step(1); inc_we = 0;
    chk("c5_busy", int'(inc_busy), 1);
    step(10); chk("c15_busy", int'(inc_busy), 1);
    step(1);  chk("c16_bit96", int'(bit_tick), 1); chk("c16_busy", int'(inc_busy), 0);
    step(3);  chk("c19_os", int'(os_tick), 1);
    step(2);  chk("c21_os", int'(os_tick), 0);
    step(1);  chk("c22_os", int'(os_tick), 1);
    step(2);  chk("c24_os", int'(os_tick), 1);

    // Resync realigns phase
    start();
    step(9); resync = 1; step(1); resync = 0;
    chk("rs_os", int'(os_tick), 0); chk("rs_phase", int'(os_phase), 0);
    step(4); chk("rs_os4", int'(os_tick), 1);
    step(4); chk("rs_mid8", int'(mid_tick), 1);

    // Enable dropped for three cycles
    start();
    step(5); enable = 0; step(3);
    chk("dis_os", int'(os_tick), 0); chk("dis_phase", int'(os_phase), 0);
    enable = 1;
    step(3); chk("en_os3", int'(os_tick), 0);
    step(1); chk("en_os4", int'(os_tick), 1);

    // Write coinciding with the bit-boundary edge takes effect at once
    start();
    step(15); inc_we = 1; inc_i = 8'd128; step(1); inc_we = 0;
    chk("wb_bit", int'(bit_tick), 1); chk("wb_busy", int'(inc_busy), 0);
    step(1); chk("wb_os1", int'(os_tick), 0);
    step(1); chk("wb_os2", int'(os_tick), 1);

    // Reset mid-bit discards the pending increment
    start();
    step(4); inc_we = 1; inc_i = 8'd96; step(1); inc_we = 0;
    step(5); chk("pre_rst_phase", int'(os_phase), 2); chk("pre_rst_busy", int'(inc_busy), 1);
    rst = 1; step(1); rst = 0;
    chk("post_rst_busy", int'(inc_busy), 0); chk("post_rst_phase", int'(os_phase), 0);
    step(3); chk("post_rst_os3", int'(os_tick), 0);
    step(1); chk("post_rst_os4", int'(os_tick), 1);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom % 150) == 0;
      enable = ($urandom % 25) != 0;
      resync = ($urandom % 60) == 0;
      inc_we = ($urandom % 20) == 0;
      inc_i  = (($urandom % 10) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      step(1);
    end
    rst = 0; enable = 1; resync = 0; inc_we = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
